shift_reg_arbiter: RTL and testbench
====================================

# shift_reg_arbiter

Round-robin arbiter and sequencer that shares one `shift_reg` instance (parameterised by SHIFT_DIRECTION/SHIFT_AMOUNT) between two requesters. Each requester submits a value and a shift count through a valid/ready handshake. The arbiter grants one request, loads the value into the shift register and lets it shift for exactly the requested number of cycles. It then captures `po` and returns the result, tagged with the requester ID, through a valid/ready response port.

## Interface

- WIDTH, 8, data width; matches the shift register's `load_value`/`po`.
- CNT_W, 4, width of the shift-count field; 0 to 2^CNT_W-1 shifts.

- clk  in  1  rising-edge clock, shared with the attached `shift_reg`.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a command.
- req0_data  in  WIDTH  value to load.
- req0_cycles  in  CNT_W  number of shifts to apply.
- req0_ready  out  1  command 0 accepted this cycle.
- req1_valid / req1_data / req1_cycles / req1_ready  same as requester 0, for requester 1.
- sr_load  out  1  drives `shift_reg` `load`.
- sr_load_value  out  WIDTH  drives `shift_reg` `load_value`.
- sr_po  in  WIDTH  from `shift_reg` `po`.
- rsp_valid  out  1  result available.
- rsp_id  out  1  requester that owns the result.
- rsp_data  out  WIDTH  captured shift-register output.
- rsp_ready  in  1  response consumer accepts the result.
- busy  out  1  high in every state except IDLE.

## Operation

- States: IDLE, LOAD, SHIFT, RESP.
- **IDLE**
  - `reqN_ready` is combinational and is high only for the arbitration winner, only while that requester's valid is high.
  - Arbitration is round-robin:
    - If both requesters are valid, the one not served last wins.
    - If only one is valid, it wins.
    - The `last` pointer resets to 1, so requester 0 wins the first contention.
  - On valid&ready, latch data, cycles and ID, then go to LOAD.
- **LOAD** (exactly 1 cycle)
  - `sr_load`=1 and `sr_load_value` = latched data.
  - Clear the shift counter `cnt` to 0.
  - Go to SHIFT.
- **SHIFT**
  - `sr_load`=0, so the shift register shifts on every edge.
  - While `cnt` != cycles, increment `cnt`.
  - When `cnt` == cycles, register `rsp_data` <= `sr_po`, then go to RESP.
  - SHIFT therefore lasts cycles+1 clocks, and the captured value equals the loaded value shifted exactly `cycles` times.
  - cycles=0 returns the loaded value unchanged.
- **RESP**
  - `rsp_valid`=1, and `rsp_id`/`rsp_data` are held stable until `rsp_ready`.
  - On `rsp_valid`&`rsp_ready`, set `last` <= `rsp_id`, drop `rsp_valid` and go to IDLE.
  - The shift register keeps shifting during RESP; this has no effect because the result is already registered.
- `sr_load_value` always shows the latched data register. `sr_load` is high only in LOAD.
- `reqN_ready` is 0 in every state except IDLE. Requests arriving while busy wait and are never dropped. Changes to `reqN_*` after acceptance have no effect.
- `rsp_data`, `rsp_id` and `cnt` are CNT_W/WIDTH-exact; `cnt` never wraps because it stops at `cycles`.

## Timing

- Reset (`rst`=0, asynchronous):
  - state=IDLE, `last`=1.
  - `sr_load`=0, `sr_load_value`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0.
  - `busy`=0, `cnt`=0.
  - `reqN_ready` follows IDLE arbitration immediately.
- Reset mid-operation aborts the job. The in-flight result is discarded, and the requester must resubmit.
- Latency: accept edge at T. LOAD occupies cycle T+1. SHIFT occupies T+2 .. T+cycles+2. `rsp_valid` first goes high in cycle T+cycles+3.
- Minimum spacing between jobs: the next accept happens no earlier than the cycle after the response handshake.
- Simultaneous valid on both requesters: exactly one `ready` goes high per accept, never both.
- `rsp_ready` held high: RESP lasts 1 cycle.
- `rsp_ready` low: `rsp_valid`/`rsp_id`/`rsp_data` are stable, and no new request is accepted.

## Test plan

Bench instantiates `shift_reg` with SHIFT_DIRECTION="RIGHT" and SHIFT_AMOUNT=1. Expected values use operands whose low bits are 0, so the result is the same under fill or rotate behaviour.

- **Reset:** `rst`=0 with activity present -> all outputs at their reset values. Release `rst`, present req0 only with data 0x90, cycles 3 -> `req0_ready` high in that cycle. `sr_load`=1 one cycle later. `rsp_valid` with `rsp_id`=0 and `rsp_data`=0x12 rises 6 cycles after the accept edge.
- **Zero shifts:** req1, data 0xA5, cycles 0 -> `rsp_data`=0xA5, `rsp_id`=1, latency 3 cycles.
- **Contention:** both requesters valid continuously; req0 0x80/7, req1 0x40/2 -> grants alternate 0,1,0,1. Results are 0x01 for req0 and 0x10 for req1. Exactly one `ready` pulse per job.
- **Backpressure:** `rsp_ready`=0 for 10 cycles -> `rsp_valid`/`rsp_data` stable, both `reqN_ready` stay 0. Raising `rsp_ready` completes the handshake and returns to IDLE.
- **Reset mid-SHIFT:** assert `rst` at cycle 2 of a 15-shift job -> immediate IDLE, no `rsp_valid`. A resubmitted job completes correctly.
- **Random soak:** 1000 cycles of random valid/data/cycles/`rsp_ready` -> every accepted request produces exactly one response with a matching ID, and the result matches the reference model.

Source files
------------

// File: rtl/shift_reg_arbiter.sv
// Round-robin arbiter/sequencer sharing one external shift register between two requesters.
// A granted job is loaded, shifted for its requested count, then returned with the requester ID.
module shift_reg_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [CNT_W-1:0] req0_cycles,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [CNT_W-1:0] req1_cycles,
  output logic             req1_ready,
  output logic             sr_load,
  output logic [WIDTH-1:0] sr_load_value,
  input  logic [WIDTH-1:0] sr_po,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StResp} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant0, grant1;

  // On contention the requester not served last wins; last_q=1 favours requester 0.
  assign grant0 = req0_valid && (!req1_valid || last_q);
  assign grant1 = req1_valid && (!req0_valid || !last_q);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    cycles_d   = cycles_q;
    cnt_d      = cnt_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    sr_load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0) begin
          data_d   = req0_data;
          cycles_d = req0_cycles;
          id_d     = 1'b0;
          state_d  = StLoad;
        end else if (grant1) begin
          data_d   = req1_data;
          cycles_d = req1_cycles;
          id_d     = 1'b1;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        sr_load = 1'b1;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        // po has shifted cnt_q times at this point, so capture when cnt_q reaches the count.
        if (cnt_q == cycles_q) begin
          rsp_data_d = sr_po;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      data_q     <= '0;
      rsp_data_q <= '0;
      cycles_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      cycles_q   <= cycles_d;
      cnt_q      <= cnt_d;
    end
  end

  assign sr_load_value = data_q;
  assign rsp_valid     = (state_q == StResp);
  assign rsp_id        = id_q;
  assign rsp_data      = rsp_data_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_shift_reg_arbiter.sv
// Directed and random bench for shift_reg_arbiter with a right-shift-by-one register model.
module tb_shift_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic [3:0] req0_cycles, req1_cycles;
  logic       sr_load;
  logic [7:0] sr_load_value, sr_po;
  logic       rsp_valid, rsp_id, rsp_ready, busy;
  logic [7:0] rsp_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shift_reg_arbiter #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_cycles(req0_cycles),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_cycles(req1_cycles),
    .req1_ready(req1_ready),
    .sr_load(sr_load), .sr_load_value(sr_load_value), .sr_po(sr_po),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  // Shift register: right by one, zero fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr_po <= '0;
    else if (sr_load) sr_po <= sr_load_value;
    else sr_po <= sr_po >> 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Submit one job on requester r, check load cycle, latency and result; rsp_ready held high.
  task automatic job(input bit r, input logic [7:0] d, input logic [3:0] c, input logic [7:0] exp);
    bit got;
    int n;
    @(negedge clk);
    rsp_ready = 1'b1;
    if (r) begin req1_valid = 1'b1; req1_data = d; req1_cycles = c; end
    else begin req0_valid = 1'b1; req0_data = d; req0_cycles = c; end
    #1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if ((r ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
      else begin @(negedge clk); #1; end
    end
    check("job_ready", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    got = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("job_sr_load", {31'd0, sr_load}, 32'd1);
        check("job_load_val", {24'd0, sr_load_value}, {24'd0, d});
      end
      if (rsp_valid === 1'b1) got = 1'b1;
    end
    check("job_latency", n, c + 3);
    check("job_rsp_id", {31'd0, rsp_id}, {31'd0, r});
    check("job_rsp_data", {24'd0, rsp_data}, {24'd0, exp});
    @(negedge clk);
    check("job_idle", {31'd0, busy}, 32'd0);
  endtask

  logic [7:0] exp_q[$];
  bit         eid_q[$];

  initial begin : main
    int grants[4];
    int ng, nr, pulses;
    bit both;
    bit got;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h55; req0_cycles = 4'd5;
    req1_valid = 1'b1; req1_data = 8'hAA; req1_cycles = 4'd2;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_sr_load", {31'd0, sr_load}, 32'd0);
    check("rst_load_val", {24'd0, sr_load_value}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready0", {31'd0, req0_ready}, 32'd1);
    check("rst_ready1", {31'd0, req1_ready}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;

    job(1'b0, 8'h90, 4'd3, 8'h12);
    job(1'b1, 8'hA5, 4'd0, 8'hA5);

    // Contention: both valid continuously, grants must alternate starting with 0.
    @(negedge clk);
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h80; req0_cycles = 4'd7;
    req1_valid = 1'b1; req1_data = 8'h40; req1_cycles = 4'd2;
    ng = 0; nr = 0; pulses = 0; both = 1'b0;
    for (int k = 0; k < 200 && nr < 4; k++) begin
      #1;
      if (req0_ready && req1_ready) both = 1'b1;
      if (req0_ready || req1_ready) begin
        pulses++;
        if (ng < 4) grants[ng] = req1_ready ? 1 : 0;
        ng++;
      end
      if (rsp_valid && rsp_ready) begin
        check("cont_rsp_id", {31'd0, rsp_id}, nr % 2);
        check("cont_rsp_data", {24'd0, rsp_data}, (nr % 2) ? 32'h10 : 32'h01);
        nr++;
      end
      if (nr < 4) @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("cont_responses", nr, 4);
    check("cont_pulses", pulses, 4);
    check("cont_both_ready", {31'd0, both}, 32'd0);
    for (int i = 0; i < 4; i++) check("cont_grant", grants[i], i % 2);

    // Backpressure: requester 0 job, then requester 1 waits while the response is held.
    @(negedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h90; req0_cycles = 4'd3;
    #1;
    check("bp_accept", {31'd0, req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h40; req1_cycles = 4'd1;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) got = 1'b1;
    end
    check("bp_rsp_seen", {31'd0, got}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      #1;
      check("bp_hold", {rsp_valid, rsp_id, req0_ready, req1_ready, rsp_data},
            {4'b1000, 8'h12});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_idle", {31'd0, busy}, 32'd0);
    check("bp_next_ready", {31'd0, req1_ready}, 32'd1);
    req1_valid = 1'b0;

    // Reset during SHIFT aborts the job.
    @(negedge clk);
    req1_valid = 1'b1; req1_data = 8'h80; req1_cycles = 4'd15;
    #1;
    check("mid_accept", {31'd0, req1_ready}, 32'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) got = 1'b1;
    end
    check("mid_no_rsp", {31'd0, got}, 32'd0);
    job(1'b1, 8'h80, 4'd4, 8'h08);

    // Random soak against a FIFO reference model.
    for (int cyc = 0; cyc < 1040; cyc++) begin
      @(negedge clk);
      if (cyc < 1000) begin
        req0_valid = $urandom_range(0, 1) == 1;
        req1_valid = $urandom_range(0, 1) == 1;
        req0_data = 8'($urandom); req0_cycles = 4'($urandom);
        req1_data = 8'($urandom); req1_cycles = 4'($urandom);
        rsp_ready = $urandom_range(0, 2) != 0;
      end else begin
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      end
      #1;
      if (req0_ready && req1_ready) check("soak_both_ready", 32'd1, 32'd0);
      if (req0_valid && req0_ready) begin
        exp_q.push_back(req0_data >> req0_cycles); eid_q.push_back(1'b0);
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back(req1_data >> req1_cycles); eid_q.push_back(1'b1);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("soak_spurious", 32'd1, 32'd0);
        else begin
          check("soak_id", {31'd0, rsp_id}, {31'd0, eid_q.pop_front()});
          check("soak_data", {24'd0, rsp_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
    check("soak_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
